// File: rtl/tx_fifo_pkg.sv
// Shared types and constants for the transmit block FIFO.
package tx_fifo_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned SIDES     = 4;
    localparam int unsigned BLOCK_W   = 128;
    localparam logic [1:0]  LAST_SIDE = 2'b11;

    typedef logic [BLOCK_W-1:0] tx_block_t;
    typedef logic [WORD_W-1:0]  tx_word_t;

    // Select one 32-bit side of a block; side 0 is the least significant word.
    function automatic tx_word_t side_word(tx_block_t blk, logic [1:0] side);
        tx_word_t w;
        unique case (side)
            2'd0:    w = blk[0*WORD_W +: WORD_W];
            2'd1:    w = blk[1*WORD_W +: WORD_W];
            2'd2:    w = blk[2*WORD_W +: WORD_W];
            default: w = blk[3*WORD_W +: WORD_W];
        endcase
        return w;
    endfunction

endpackage

// File: rtl/tx_fifo_ctrl_if.sv
// Handshake bundle between the transmit block FIFO and its surroundings.
// Optional macro: TX_FIFO_OVF_FLAG_EN adds the sticky ovf flag.
interface tx_fifo_ctrl_if;
    import tx_fifo_pkg::*;

    logic      wr_en;
    tx_block_t wr_data;
    logic      full;
    logic      empty;
    logic      rd_ready;
    logic      rd_valid;
    tx_word_t  rd_data;
    logic [1:0] head_side;
    logic      count_en1;
`ifdef TX_FIFO_OVF_FLAG_EN
    logic      ovf;
`endif

    // FIFO side
    modport slave (
        input  wr_en, wr_data, rd_ready, head_side,
`ifdef TX_FIFO_OVF_FLAG_EN
        output ovf,
`endif
        output full, empty, rd_valid, rd_data, count_en1
    );

    // Producer / consumer / side-counter side
    modport master (
        output wr_en, wr_data, rd_ready, head_side,
`ifdef TX_FIFO_OVF_FLAG_EN
        input  ovf,
`endif
        input  full, empty, rd_valid, rd_data, count_en1
    );

endinterface

// File: rtl/tx_fifo_mem.sv
// Register array for the transmit FIFO: one write port, one full-block read port.
// Contents are deliberately not reset; the control logic never exposes stale entries.
module tx_fifo_mem
    import tx_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  tx_block_t        wdata,
    input  logic [PTR_W-1:0] raddr,
    output tx_block_t        rdata
);

    tx_block_t mem [DEPTH];

    // Store the incoming block on an accepted write.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the head entry.
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/tx_fifo_ctrl.sv
// Transmit block FIFO: buffers 128-bit blocks and emits them as four 32-bit sides,
// driving the external side counter through count_en1 and reading back head_side.
// Optional macro: TX_FIFO_OVF_FLAG_EN adds a sticky overflow flag on bus.ovf.
module tx_fifo_ctrl
    import tx_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           n_rst,
    tx_fifo_ctrl_if.slave  bus
);

    localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE = (PTR_W + 1)'(1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic      full, empty;
    logic      wr_fire, accepted, retire;
    tx_block_t head_block;

    tx_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr_q),
        .wdata (bus.wr_data),
        .raddr (rd_ptr_q),
        .rdata (head_block)
    );

    // Flags and handshake decode; full uses the pre-edge count so a same-cycle
    // retire never frees room for the write.
    always_comb begin
        full     = (count_q == COUNT_MAX);
        empty    = (count_q == '0);
        wr_fire  = bus.wr_en && !full;
        accepted = !empty && bus.rd_ready;
        retire   = accepted && (bus.head_side == LAST_SIDE);
    end

    // Output drive; rd_data is forced to zero while nothing is resident.
    always_comb begin
        bus.full      = full;
        bus.empty     = empty;
        bus.rd_valid  = !empty;
        bus.count_en1 = accepted;
        bus.rd_data   = empty ? '0 : side_word(head_block, bus.head_side);
    end

    // Pointer and occupancy next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (retire) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        unique case ({wr_fire, retire})
            2'b10:   count_d = count_q + COUNT_ONE;
            2'b01:   count_d = count_q - COUNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef TX_FIFO_OVF_FLAG_EN
    logic ovf_q;

    // Sticky overflow: any push attempt while full sets it until reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovf_q <= 1'b0;
        end else if (bus.wr_en && full) begin
            ovf_q <= 1'b1;
        end
    end

    // Expose the overflow flag.
    always_comb begin
        bus.ovf = ovf_q;
    end
`endif

endmodule

// File: tb/tb_tx_fifo_ctrl.sv
// Self-checking bench for tx_fifo_ctrl with a stand-in side counter and a word scoreboard.
module tb_tx_fifo_ctrl;
    import tx_fifo_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    tx_fifo_ctrl_if bus();

    tx_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Stand-in for tx_counter_idx in the parent.
    logic [1:0] side;
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)             side <= 2'd0;
        else if (bus.count_en1) side <= side + 2'd1;
    end
    assign bus.head_side = side;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model
    int         m_count;
    tx_word_t   exp_q[$];
    logic [1:0] m_side;
    logic       m_ovf;

    // Outputs sampled at the last negedge
    logic     s_empty, s_full, s_valid, s_cen;
    tx_word_t s_data;

    typedef struct {
        logic      we;
        tx_block_t wd;
        logic      rr;
        logic      e_empty;
        logic      e_full;
        logic      e_valid;
        logic      e_cen;
        tx_word_t  e_data;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_count = 0;
        m_side  = 2'd0;
        m_ovf   = 1'b0;
    endtask

    // One clock: drive inputs, check outputs at negedge, advance the model, step to posedge+1.
    task automatic cycle(input logic we, input tx_block_t wd, input logic rr);
        logic acc, wf;
        bus.wr_en    = we;
        bus.wr_data  = wd;
        bus.rd_ready = rr;
        @(negedge clk);
        s_empty = bus.empty;
        s_full  = bus.full;
        s_valid = bus.rd_valid;
        s_cen   = bus.count_en1;
        s_data  = bus.rd_data;
        check("empty", 32'(s_empty), 32'(m_count == 0));
        check("full", 32'(s_full), 32'(m_count == DEPTH));
        check("rd_valid", 32'(s_valid), 32'(m_count != 0));
        check("count_en1", 32'(s_cen), 32'((m_count != 0) && rr));
        check("rd_data", s_data, (m_count != 0) ? exp_q[0] : 32'h0);
        check("head_side", 32'(side), 32'(m_side));
`ifdef TX_FIFO_OVF_FLAG_EN
        check("ovf", 32'(bus.ovf), 32'(m_ovf));
        if (we && m_count == DEPTH) m_ovf = 1'b1;
`endif
        acc = (m_count != 0) && rr;
        wf  = we && (m_count != DEPTH);
        if (acc) begin
            void'(exp_q.pop_front());
            if (m_side == LAST_SIDE) m_count--;
            m_side = m_side + 2'd1;
        end
        if (wf) begin
            for (int s = 0; s < SIDES; s++) exp_q.push_back(wd[s*WORD_W +: WORD_W]);
            m_count++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst        = 1'b0;
        bus.wr_en    = 1'b0;
        bus.rd_ready = 1'b0;
        model_clear();
        #2;
        check("rst_empty", 32'(bus.empty), 32'd1);
        check("rst_full", 32'(bus.full), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    function automatic tx_block_t mk_block(input logic [7:0] id);
        tx_block_t b;
        for (int s = 0; s < SIDES; s++) b[s*WORD_W +: WORD_W] = {id, 8'(s), 16'($urandom)};
        return b;
    endfunction

    initial begin
        tx_block_t b0;
        int wr_n, cyc, prev;
        logic we;

        bus.wr_en    = 1'b0;
        bus.wr_data  = '0;
        bus.rd_ready = 1'b0;
        b0 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;

        // Idle, single block streamed at full rate, then idle again.
        tbl[0] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{1'b1, b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hAAAA0000};
        tbl[3] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBBBB0001};
        tbl[4] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hCCCC0002};
        tbl[5] = '{1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hDDDD0003};
        tbl[6] = '{1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        do_reset();
        for (int i = 0; i < 7; i++) begin
            cycle(tbl[i].we, tbl[i].wd, tbl[i].rr);
            check("tbl_empty", 32'(s_empty), 32'(tbl[i].e_empty));
            check("tbl_full", 32'(s_full), 32'(tbl[i].e_full));
            check("tbl_valid", 32'(s_valid), 32'(tbl[i].e_valid));
            check("tbl_cen", 32'(s_cen), 32'(tbl[i].e_cen));
            check("tbl_data", s_data, tbl[i].e_data);
        end
        check("tbl_side_end", 32'(side), 32'd0);

        // Fill to full, drop a fifth push, then retire while pushing.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, mk_block(8'h10 + 8'(i)), 1'b0);
        cycle(1'b1, mk_block(8'hEE), 1'b0);
        check("fill_full", 32'(s_full), 32'd1);
        cycle(1'b0, '0, 1'b0);
`ifdef TX_FIFO_OVF_FLAG_EN
        check("ovf_set", 32'(bus.ovf), 32'd1);
`endif
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
        cycle(1'b1, mk_block(8'hEF), 1'b1);
        check("retire_drop_full", 32'(s_full), 32'd1);
        cycle(1'b0, '0, 1'b0);
        check("after_retire_full", 32'(s_full), 32'd0);
        cycle(1'b1, mk_block(8'h20), 1'b0);
        cycle(1'b0, '0, 1'b0);
        check("refill_full", 32'(s_full), 32'd1);
        cyc = 0;
        while (m_count != 0 && cyc < 40) begin
            cycle(1'b0, '0, 1'b1);
            cyc++;
        end
        check("drain_in_budget", 32'(cyc < 40), 32'd1);
`ifdef TX_FIFO_OVF_FLAG_EN
        check("ovf_sticky", 32'(bus.ovf), 32'd1);
`endif

        // Random concurrent stream of 8 blocks.
        do_reset();
        wr_n = 0;
        cyc  = 0;
        while ((wr_n < 8 || m_count != 0) && cyc < 400) begin
            we   = (wr_n < 8) && ($urandom_range(0, 3) != 0);
            prev = m_count;
            cycle(we, mk_block(8'h80 + 8'(wr_n)), 1'($urandom_range(0, 1)));
            if (we && prev != DEPTH) wr_n++;
            cyc++;
        end
        check("stream_in_budget", 32'(cyc < 400), 32'd1);
        cycle(1'b0, '0, 1'b1);

        // Reset in the middle of a block.
        do_reset();
        cycle(1'b1, mk_block(8'h30), 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b1);
        bus.rd_ready = 1'b1;
        n_rst = 1'b0;
        #2;
        check("mid_rst_empty", 32'(bus.empty), 32'd1);
        check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
        check("mid_rst_cen", 32'(bus.count_en1), 32'd0);
        check("mid_rst_data", bus.rd_data, 32'h0);
        check("mid_rst_side", 32'(side), 32'd0);
        model_clear();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        b0 = mk_block(8'h40);
        cycle(1'b1, b0, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("post_rst_side0", s_data, b0[31:0]);
        for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
